// File: rtl/fixp_expand_acc.sv
// fixp_expand_acc
//   Widens narrow signed fixed-point samples S(NB_XI,NBF_XI) to
//   S(NB_XO,NBF_XO) and sums N_ACC of them per block, emitting one wide
//   block sum through a valid/ready output register.
//
//   Build option: define FIXP_ACC_SAT_EN to make every accumulation step
//   saturate and to add the sticky o_sat port. Without it, additions wrap
//   modulo 2^NB_XO and the integrator provides the headroom.
//
// Ports
//   i_clock    rising-edge clock
//   i_reset_n  synchronous active-low reset
//   i_data     narrow input sample
//   i_valid    i_data valid
//   o_ready    a sample can be accepted this cycle
//   i_clear    discard the current partial block
//   o_data     block sum (held until popped)
//   o_valid    o_data holds an unread block sum
//   i_ready    downstream accepts o_data
//   o_sat      sticky saturation flag (FIXP_ACC_SAT_EN only)

module fixp_expand_acc #(
    parameter int NB_XI  = 8,
    parameter int NBF_XI = 6,
    parameter int NB_XO  = 20,
    parameter int NBF_XO = 12,
    parameter int N_ACC  = 4
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic [NB_XI-1:0]  i_data,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_clear,
    output logic [NB_XO-1:0]  o_data,
    output logic              o_valid,
    input  logic              i_ready
`ifdef FIXP_ACC_SAT_EN
    ,
    output logic              o_sat
`endif
);

    localparam int CW = (N_ACC > 1) ? $clog2(N_ACC) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_ACC - 1);
    localparam int PAD  = (NBF_XO >= NBF_XI) ? (NBF_XO - NBF_XI) : 0;
    localparam int DROP = (NBF_XO >= NBF_XI) ? 0 : (NBF_XI - NBF_XO);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]               state;
    logic [NB_XO-1:0]         acc;
    logic [CW-1:0]            cnt;

    logic signed [NB_XI-1:0]  x_in;
    logic signed [NB_XO-1:0]  x_wide;
    logic [NB_XO-1:0]         acc_base;
    logic [CW-1:0]            cnt_base;
    logic [NB_XO-1:0]         sum_red;
    logic                     acc_en;
    logic                     pop;
    logic                     complete;

`ifdef FIXP_ACC_SAT_EN
    logic [NB_XO:0]           sum;
    logic                     ovf;
    logic                     sat;
`else
    // Wrapping mode keeps only the low NB_XO bits, so the carry bit of the
    // NB_XO+1-bit addition is never formed.
    logic [NB_XO-1:0]         sum;
`endif

    // Widening: sign-extend, then either append fractional zeros or
    // floor-truncate surplus fractional bits with an arithmetic shift.
    always_comb begin
        x_in = i_data;
        if (NBF_XO >= NBF_XI) begin
            x_wide = NB_XO'(x_in) <<< PAD;
        end else begin
            x_wide = NB_XO'(x_in >>> DROP);
        end
    end

    assign o_valid  = state[0];
    assign o_ready  = ~state[0] | i_ready;
    assign acc_en   = i_valid & o_ready;
    assign pop      = state[0] & i_ready;

    // A clear in the same cycle as an accepted sample starts a fresh block
    // with that sample, so both operands are taken from the cleared values.
    assign acc_base = i_clear ? '0 : acc;
    assign cnt_base = i_clear ? '0 : cnt;
    assign complete = acc_en & ~i_clear & (cnt == LAST);

`ifdef FIXP_ACC_SAT_EN
    always_comb begin
        sum = {acc_base[NB_XO-1], acc_base} + {x_wide[NB_XO-1], x_wide};
        ovf = sum[NB_XO] ^ sum[NB_XO-1];
        if (ovf) begin
            sum_red = sum[NB_XO] ? {1'b1, {(NB_XO-1){1'b0}}}
                                 : {1'b0, {(NB_XO-1){1'b1}}};
        end else begin
            sum_red = sum[NB_XO-1:0];
        end
    end
    assign o_sat = sat;
`else
    always_comb begin
        sum     = acc_base + x_wide;
        sum_red = sum;
    end
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state  <= ST_ACCUM;
            acc    <= '0;
            cnt    <= '0;
            o_data <= '0;
`ifdef FIXP_ACC_SAT_EN
            sat    <= 1'b0;
`endif
        end else begin
            if (pop) begin
                state <= ST_ACCUM;
            end
            if (i_clear) begin
                acc <= '0;
                cnt <= '0;
            end
            if (acc_en) begin
                if (complete) begin
                    // Completing a block overrides a same-cycle pop so
                    // back-to-back blocks stay in HOLD.
                    o_data <= sum_red;
                    state  <= ST_HOLD;
                    acc    <= '0;
                    cnt    <= '0;
                end else begin
                    acc <= sum_red;
                    cnt <= cnt_base + CW'(1);
                end
            end
`ifdef FIXP_ACC_SAT_EN
            if (acc_en && ovf) begin
                sat <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fixp_expand_acc.sv
// Testbench for fixp_expand_acc: directed vector table, hand-written
// backpressure / clear / reset sequences, a narrowed-output overflow case on
// a second instance, and randomized traffic checked against a block-level
// reference model (queue of accepted samples summed at block end).

module tb_fixp_expand_acc;

    localparam int N_BLK  = 4;
    localparam int SCALE  = 64;   // 2^(NBF_XO - NBF_XI) for the default build

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  d;
    logic        v, c, r;
    logic        o_rdy, o_vld;
    logic [19:0] o_dat;

    logic [7:0]  s_d;
    logic        s_v, s_c, s_r;
    logic        s_rdy, s_vld;
    logic [9:0]  s_dat;
`ifdef FIXP_ACC_SAT_EN
    logic        d_sat;
    logic        s_sat;
`endif

    fixp_expand_acc dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_data    (d),
        .i_valid   (v),
        .o_ready   (o_rdy),
        .i_clear   (c),
        .o_data    (o_dat),
        .o_valid   (o_vld),
        .i_ready   (r)
`ifdef FIXP_ACC_SAT_EN
        ,
        .o_sat     (d_sat)
`endif
    );

    fixp_expand_acc #(
        .NB_XI  (8),
        .NBF_XI (6),
        .NB_XO  (10),
        .NBF_XO (6),
        .N_ACC  (8)
    ) dut_small (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_data    (s_d),
        .i_valid   (s_v),
        .o_ready   (s_rdy),
        .i_clear   (s_c),
        .o_data    (s_dat),
        .o_valid   (s_vld),
        .i_ready   (s_r)
`ifdef FIXP_ACC_SAT_EN
        ,
        .o_sat     (s_sat)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: samples of the open block and the held result.
    int          blk[$];
    logic [19:0] m_data;
    bit          m_valid;

    function automatic logic [19:0] block_sum();
        longint      s = 0;
        logic [63:0] t;
        foreach (blk[i]) s += longint'(blk[i]) * SCALE;
        t = s;
        return t[19:0];
    endfunction

    task automatic cycle(input logic rn, input logic [7:0] dd, input logic vv,
                         input logic cc, input logic rr);
        bit          ready, accept, popm, done;
        byte         sb;
        logic [19:0] xw;
        rst_n = rn; d = dd; v = vv; c = cc; r = rr;
        #1;
        if (dd == 8'h80) begin
            xw = dut.x_wide;
            check("x_wide_minus2", xw, 20'hFE000);
        end
        if (!rn) begin
            blk.delete();
            m_valid = 0;
            m_data  = '0;
        end else begin
            ready  = !m_valid || rr;
            accept = vv && ready;
            popm   = m_valid && rr;
            done   = 0;
            if (cc) blk.delete();
            if (accept) begin
                sb = dd;
                blk.push_back(int'(sb));
                if (blk.size() == N_BLK) begin
                    m_data = block_sum();
                    blk.delete();
                    done = 1;
                end
            end
            if (done) m_valid = 1;
            else if (popm) m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, o_vld, m_valid);
        check({tag, ".ready"}, o_rdy, (!m_valid) || r);
        check({tag, ".data"},  o_dat, m_data);
    endtask

    typedef struct {
        logic [7:0]  dd;
        logic        vv;
        logic        cc;
        logic        ev;
        logic [19:0] ed;
    } vec_t;

    function automatic vec_t mk(logic [7:0] dd, logic vv, logic cc, logic ev, logic [19:0] ed);
        vec_t t;
        t.dd = dd; t.vv = vv; t.cc = cc; t.ev = ev; t.ed = ed;
        return t;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        logic [9:0] s_exp;

        rst_n = 0; d = '0; v = 0; c = 0; r = 1;
        s_d = '0; s_v = 0; s_c = 0; s_r = 1;
        m_valid = 0; m_data = '0;

        @(negedge clk);
        cycle(0, 8'h00, 0, 0, 1);
        cycle(0, 8'h00, 0, 0, 1);
        check("reset.valid", o_vld, 1'b0);
        check("reset.data",  o_dat, 20'h0);
        check("reset.ready", o_rdy, 1'b1);
        check("reset.small_valid", s_vld, 1'b0);
`ifdef FIXP_ACC_SAT_EN
        check("reset.sat", d_sat, 1'b0);
`endif

        // +1.0 x4 -> +4.0
        for (int i = 0; i < 3; i++) tbl.push_back(mk(8'h40, 1, 0, 0, 20'h0));
        tbl.push_back(mk(8'h40, 1, 0, 1, 20'h04000));
        tbl.push_back(mk(8'h00, 0, 0, 0, 20'h0));
        // -2.0 x4 -> -8.0
        for (int i = 0; i < 3; i++) tbl.push_back(mk(8'h80, 1, 0, 0, 20'h0));
        tbl.push_back(mk(8'h80, 1, 0, 1, 20'hF8000));
        tbl.push_back(mk(8'h00, 0, 0, 0, 20'h0));
        // two +1.0, clear with -1.0, three +1.0 -> +2.0
        tbl.push_back(mk(8'h40, 1, 0, 0, 20'h0));
        tbl.push_back(mk(8'h40, 1, 0, 0, 20'h0));
        tbl.push_back(mk(8'hC0, 1, 1, 0, 20'h0));
        tbl.push_back(mk(8'h40, 1, 0, 0, 20'h0));
        tbl.push_back(mk(8'h40, 1, 0, 0, 20'h0));
        tbl.push_back(mk(8'h40, 1, 0, 1, 20'h02000));
        tbl.push_back(mk(8'h00, 0, 0, 0, 20'h0));

        foreach (tbl[i]) begin
            cycle(1, tbl[i].dd, tbl[i].vv, tbl[i].cc, 1);
            check($sformatf("tbl[%0d].valid", i), o_vld, tbl[i].ev);
            if (tbl[i].ev) check($sformatf("tbl[%0d].data", i), o_dat, tbl[i].ed);
        end

        // Backpressure: result held, input stalled, then pop+accept together.
        for (int i = 0; i < 4; i++) cycle(1, 8'h40, 1, 0, 0);
        check("bp.valid", o_vld, 1'b1);
        check("bp.data",  o_dat, 20'h04000);
        check("bp.ready", o_rdy, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle(1, 8'h40, 1, 0, 0);
            check("bp.hold_data",  o_dat, 20'h04000);
            check("bp.hold_ready", o_rdy, 1'b0);
        end
        cycle(1, 8'h40, 1, 0, 1);
        check("bp.pop_accept_valid", o_vld, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1, 8'h40, 1, 0, 1);
        check("bp.second_valid", o_vld, 1'b1);
        check("bp.second_data",  o_dat, 20'h04000);
        cycle(1, 8'h00, 0, 0, 1);
        check_model("bp.after");

        // Reset in the middle of a block discards the partial sum.
        for (int i = 0; i < 3; i++) cycle(1, 8'h40, 1, 0, 1);
        cycle(0, 8'h00, 0, 0, 1);
        check("rst.valid", o_vld, 1'b0);
        check("rst.data",  o_dat, 20'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 8'h40, 1, 0, 1);
            check("rst.no_early_output", o_vld, 1'b0);
        end
        cycle(1, 8'h40, 1, 0, 1);
        check("rst.valid_after", o_vld, 1'b1);
        check("rst.data_after",  o_dat, 20'h04000);
        cycle(1, 8'h00, 0, 0, 1);

        // Narrow accumulator: eight samples of 8'h7F overflow 10 bits.
`ifdef FIXP_ACC_SAT_EN
        s_exp = 10'h1FF;
`else
        s_exp = 10'h3F8;
`endif
        for (int k = 0; k < 8; k++) begin
            s_d = 8'h7F;
            s_v = 1;
            cycle(1, 8'h00, 0, 0, 1);
            if (k == 3) begin
                check("small.no_early_valid", s_vld, 1'b0);
`ifdef FIXP_ACC_SAT_EN
                check("small.sat_before_ovf", s_sat, 1'b0);
`endif
            end
`ifdef FIXP_ACC_SAT_EN
            if (k == 4) check("small.sat_set", s_sat, 1'b1);
`endif
        end
        s_v = 0;
        check("small.valid", s_vld, 1'b1);
        check("small.data",  s_dat, s_exp);
        cycle(1, 8'h00, 0, 0, 1);
        check("small.popped", s_vld, 1'b0);
`ifdef FIXP_ACC_SAT_EN
        check("small.sat_sticky", s_sat, 1'b1);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            logic       rn, vv, cc, rr;
            logic [7:0] dd;
            rn = ($urandom % 150) != 0;
            dd = 8'($urandom);
            vv = ($urandom % 4) != 0;
            cc = ($urandom % 20) == 0;
            rr = ($urandom % 3) != 0;
            cycle(rn, dd, vv, cc, rr);
            check_model($sformatf("rand[%0d]", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fixp_expand_acc.md
Name: fixp_expand_acc

Overview:
- Input-side companion of the output saturating/truncating fixed-point narrower.
- Takes narrow signed fixed-point samples S(NB_XI,NBF_XI) and widens each one to S(NB_XO,NBF_XO).
- Accumulates N_ACC widened samples per block and emits one wide sum per block.
- Valid/ready handshake on both sides; sits between the narrow sample source and the wide datapath.

Parameters:
- NB_XI, 8, input total bits (signed two's complement).
- NBF_XI, 6, input fractional bits.
- NB_XO, 20, output/accumulator total bits; NBI_XO = NB_XO-NBF_XO must be >= NBI_XI = NB_XI-NBF_XI.
- NBF_XO, 12, output fractional bits.
- N_ACC, 4, samples per block; legal range 2..256. Counter width is clog2(N_ACC).

Ports:
- i_clock  in  1  clock; all logic on the rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_data  in  NB_XI  narrow input sample.
- i_valid  in  1  i_data is valid.
- o_ready  out  1  block can accept a sample this cycle.
- i_clear  in  1  abort the current partial block.
- o_data  out  NB_XO  block sum.
- o_valid  out  1  o_data holds an unread block sum.
- i_ready  in  1  downstream accepts o_data.
- o_sat  out  1  sticky saturation flag; exists only with FIXP_ACC_SAT_EN.

Behaviour:
- Reset: i_reset_n sampled low at a clock edge sets acc=0, cnt=0, o_valid=0, o_data=0, o_sat=0. Reset mid-block discards the partial sum and any held result.
- Widening conversion (combinational, applied per sample):
  - Fractional part: if NBF_XO >= NBF_XI, append (NBF_XO-NBF_XI) zeros. Otherwise drop the low (NBF_XI-NBF_XO) bits (floor truncation).
  - Integer part: sign-extend by (NBI_XO-NBI_XI) bits. No conversion-stage saturation exists.
- Handshake:
  - Sample accepted ("acc_en") when i_valid && o_ready.
  - Output transfer ("pop") when o_valid && i_ready.
  - o_ready = ~o_valid | i_ready, so a sample can be accepted in the same cycle as a pop.
- States:
  - ACCUM (o_valid=0).
  - HOLD (o_valid=1, result waiting).
  - ACCUM->HOLD on the acc_en that completes a block.
  - HOLD->ACCUM on a pop without a block-completing acc_en.
  - HOLD->HOLD on a pop plus a block-completing acc_en in the same cycle (back-to-back blocks).
- On acc_en with cnt < N_ACC-1: acc <= acc + x_wide; cnt <= cnt+1.
- On acc_en with cnt == N_ACC-1:
  - o_data <= acc + x_wide; o_valid <= 1.
  - acc <= 0; cnt <= 0.
  - Latency: the result is visible the cycle after the last sample is accepted.
- i_clear:
  - Sets acc=0, cnt=0. Never affects o_data or o_valid.
  - i_clear together with acc_en: clear wins over the old partial sum. The sample becomes the first of a new block (acc <= x_wide, cnt <= 1).
- No acc_en and no pop: all registers hold.
- o_data is stable while o_valid=1 and i_ready=0.
- Arithmetic: the addition is NB_XO+1 bits wide, then reduced to NB_XO bits per the Optional Feature section.

Optional Feature:
- Macro: FIXP_ACC_SAT_EN.
- Defined:
  - Each addition saturates to [-2^(NB_XO-1), 2^(NB_XO-1)-1] (10'h200 / 10'h1FF for NB_XO=10).
  - The o_sat port exists. It sets on any saturating addition and clears only on reset.
- Undefined:
  - Addition wraps modulo 2^NB_XO.
  - The o_sat port is absent.
  - The integrator guarantees headroom: NBI_XO >= NBI_XI + clog2(N_ACC).

Test Plan:
- Defaults; four accepted samples 8'h40 (+1.0), i_ready=1 -> one cycle after the 4th sample: o_valid=1, o_data=20'h04000 (+4.0), then o_valid drops.
- Defaults; four samples 8'h80 (-2.0) -> o_data=20'hF8000 (-8.0); every intermediate widened value equals 20'hFE000.
- Defaults; i_ready=0 after a completed block -> o_ready=0 and o_data held. Raise i_ready while 4 more samples of 8'h40 stream in -> pop and accept occur in the same cycle, no sample lost, the second sum is 20'h04000.
- Defaults; two samples of 8'h40, then i_clear with i_valid=1 and i_data=8'hC0 (-1.0), then three samples of 8'h40 -> o_data=20'h02000 (+2.0).
- NB_XO=10, NBF_XO=6, N_ACC=8; eight samples 8'h7F -> with FIXP_ACC_SAT_EN: o_data=10'h1FF, o_sat=1. Without the macro: o_data=10'h3F8 (wrap).
- i_reset_n low for one cycle after 3 of 4 samples, then 4 samples of 8'h40 -> no output before the new 4th sample; o_data=20'h04000.
